iob_fp_add_align: RTL and testbench



---
 rtl/iob_fp_add_align.sv | 198 +++++++++++++++++++
 tb/tb_iob_fp_add_align.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/iob_fp_add_align.sv
// Floating-point add/subtract front end: unpack and swap, align with sticky, add/sub.
// Produces sign, biased exponent and an unnormalized {mantissa, G, R, S} for the round/normalize stage.
module iob_fp_add_align #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [EXP_W+DATA_W-1:0]   op_a_i,
    input  logic [EXP_W+DATA_W-1:0]   op_b_i,
    input  logic                      sub_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      sign_o,
    output logic [EXP_W-1:0]          exponent_o,
    output logic [DATA_W+2:0]         mantissa_o,
    output logic                      special_o
);
    localparam int OP_W = EXP_W + DATA_W;
    localparam int MW   = DATA_W + 3;

    // Right shift that folds every discarded bit into bit 0.
    function automatic logic [MW-1:0] align_sticky(input logic [MW-1:0] m, input logic [EXP_W-1:0] sh);
        logic [MW-1:0] lost;
        logic [MW-1:0] res;
        if (32'(sh) >= MW) begin
            res    = '0;
            res[0] = |m;
        end else begin
            lost   = m & ~({MW{1'b1}} << sh);
            res    = m >> sh;
            res[0] = res[0] | (|lost) | m[0];
        end
        return res;
    endfunction

    logic              advance;
    logic              sign_a, sign_b, spec_a, spec_b, a_is_l;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [DATA_W-1:0] mant_a, mant_b;

    logic              vld_p1_d, vld_p1_q, sign_l_p1_d, sign_l_p1_q, sign_s_p1_d, sign_s_p1_q;
    logic              spec_p1_d, spec_p1_q, spec_sign_p1_d, spec_sign_p1_q;
    logic [EXP_W-1:0]  exp_l_p1_d, exp_l_p1_q, diff_p1_d, diff_p1_q;
    logic [DATA_W-1:0] mant_l_p1_d, mant_l_p1_q, mant_s_p1_d, mant_s_p1_q;

    logic              vld_p2_d, vld_p2_q, sign_l_p2_d, sign_l_p2_q, sign_s_p2_d, sign_s_p2_q;
    logic              spec_p2_d, spec_p2_q, spec_sign_p2_d, spec_sign_p2_q;
    logic [EXP_W-1:0]  exp_l_p2_d, exp_l_p2_q;
    logic [MW-1:0]     ml_p2_d, ml_p2_q, ms_p2_d, ms_p2_q;

    logic              eff_sub;
    logic [MW:0]       sum;
    logic              out_valid_d, out_valid_q, sign_d, sign_q, special_d, special_q;
    logic [EXP_W-1:0]  exponent_d, exponent_q;
    logic [MW-1:0]     mantissa_d, mantissa_q;

    // S1: unpack, effective sign of B, swap so L holds the larger magnitude
    always_comb begin
        advance = ~out_valid_q | out_ready_i;
        sign_a  = op_a_i[OP_W-1];
        sign_b  = op_b_i[OP_W-1] ^ sub_i;
        exp_a   = op_a_i[OP_W-2 -: EXP_W];
        exp_b   = op_b_i[OP_W-2 -: EXP_W];
        mant_a  = {|exp_a, op_a_i[DATA_W-2:0] & {(DATA_W-1){|exp_a}}};
        mant_b  = {|exp_b, op_b_i[DATA_W-2:0] & {(DATA_W-1){|exp_b}}};
        spec_a  = &exp_a;
        spec_b  = &exp_b;
        a_is_l  = {exp_a, mant_a} >= {exp_b, mant_b};

        vld_p1_d       = vld_p1_q;
        sign_l_p1_d    = sign_l_p1_q;
        sign_s_p1_d    = sign_s_p1_q;
        spec_p1_d      = spec_p1_q;
        spec_sign_p1_d = spec_sign_p1_q;
        exp_l_p1_d     = exp_l_p1_q;
        diff_p1_d      = diff_p1_q;
        mant_l_p1_d    = mant_l_p1_q;
        mant_s_p1_d    = mant_s_p1_q;
        if (advance) begin
            vld_p1_d = in_valid_i;
            if (in_valid_i) begin
                sign_l_p1_d    = a_is_l ? sign_a : sign_b;
                sign_s_p1_d    = a_is_l ? sign_b : sign_a;
                exp_l_p1_d     = a_is_l ? exp_a : exp_b;
                diff_p1_d      = a_is_l ? exp_a - exp_b : exp_b - exp_a;
                mant_l_p1_d    = a_is_l ? mant_a : mant_b;
                mant_s_p1_d    = a_is_l ? mant_b : mant_a;
                spec_p1_d      = spec_a | spec_b;
                spec_sign_p1_d = spec_a ? sign_a : sign_b;
            end
        end
    end

    // S2: align the smaller mantissa with sticky collection
    always_comb begin
        vld_p2_d       = vld_p2_q;
        sign_l_p2_d    = sign_l_p2_q;
        sign_s_p2_d    = sign_s_p2_q;
        spec_p2_d      = spec_p2_q;
        spec_sign_p2_d = spec_sign_p2_q;
        exp_l_p2_d     = exp_l_p2_q;
        ml_p2_d        = ml_p2_q;
        ms_p2_d        = ms_p2_q;
        if (advance) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                sign_l_p2_d    = sign_l_p1_q;
                sign_s_p2_d    = sign_s_p1_q;
                spec_p2_d      = spec_p1_q;
                spec_sign_p2_d = spec_sign_p1_q;
                exp_l_p2_d     = exp_l_p1_q;
                ml_p2_d        = {mant_l_p1_q, 3'b000};
                ms_p2_d        = align_sticky({mant_s_p1_q, 3'b000}, diff_p1_q);
            end
        end
    end

    // S3: add/subtract; a carry shifts right once, keeping the dropped bit as sticky
    always_comb begin
        eff_sub     = sign_l_p2_q ^ sign_s_p2_q;
        sum         = eff_sub ? {1'b0, ml_p2_q} - {1'b0, ms_p2_q} : {1'b0, ml_p2_q} + {1'b0, ms_p2_q};
        out_valid_d = out_valid_q;
        sign_d      = sign_q;
        exponent_d  = exponent_q;
        mantissa_d  = mantissa_q;
        special_d   = special_q;
        if (advance) begin
            out_valid_d = vld_p2_q;
            if (vld_p2_q) begin
                special_d  = spec_p2_q;
                sign_d     = sign_l_p2_q;
                exponent_d = exp_l_p2_q;
                mantissa_d = sum[MW-1:0];
                if (spec_p2_q) begin
                    sign_d     = spec_sign_p2_q;
                    exponent_d = '1;
                    mantissa_d = '0;
                end else if (sum == '0) begin
                    sign_d     = sign_l_p2_q & sign_s_p2_q;
                    exponent_d = '0;
                    mantissa_d = '0;
                end else if (sum[MW]) begin
                    exponent_d = exp_l_p2_q + EXP_W'(1);
                    mantissa_d = {sum[MW:2], sum[1] | sum[0]};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            exponent_q  <= '0;
            mantissa_q  <= '0;
            special_q   <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            exponent_q  <= exponent_d;
            mantissa_q  <= mantissa_d;
            special_q   <= special_d;
        end
    end

    always_ff @(posedge clk_i) begin
        sign_l_p1_q    <= sign_l_p1_d;
        sign_s_p1_q    <= sign_s_p1_d;
        spec_p1_q      <= spec_p1_d;
        spec_sign_p1_q <= spec_sign_p1_d;
        exp_l_p1_q     <= exp_l_p1_d;
        diff_p1_q      <= diff_p1_d;
        mant_l_p1_q    <= mant_l_p1_d;
        mant_s_p1_q    <= mant_s_p1_d;
        sign_l_p2_q    <= sign_l_p2_d;
        sign_s_p2_q    <= sign_s_p2_d;
        spec_p2_q      <= spec_p2_d;
        spec_sign_p2_q <= spec_sign_p2_d;
        exp_l_p2_q     <= exp_l_p2_d;
        ml_p2_q        <= ml_p2_d;
        ms_p2_q        <= ms_p2_d;
    end

    assign in_ready_o  = advance;
    assign out_valid_o = out_valid_q;
    assign sign_o      = sign_q;
    assign exponent_o  = exponent_q;
    assign mantissa_o  = mantissa_q;
    assign special_o   = special_q;

endmodule

// File: tb/tb_iob_fp_add_align.sv
// Scoreboard bench for iob_fp_add_align: directed operands with hand-computed results,
// back-pressure toggling, and reset while operations are in flight.
module tb_iob_fp_add_align;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] op_a_i = '0, op_b_i = '0;
    logic        sub_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
    logic        in_ready_o, out_valid_o, sign_o, special_o;
    logic [7:0]  exponent_o;
    logic [26:0] mantissa_o;

    iob_fp_add_align #(.DATA_W(24), .EXP_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .sub_i(sub_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .sign_o(sign_o), .exponent_o(exponent_o),
        .mantissa_o(mantissa_o), .special_o(special_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sg;
        logic [7:0]  e;
        logic [26:0] m;
        logic        sp;
    } exp_t;

    exp_t        q[$];
    logic [31:0] va[20], vb[20];
    logic        vs[20];
    exp_t        ve[20];
    int          nv = 0;
    int          tests = 0, fails = 0;
    logic        pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic addv(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic sg, input logic [7:0] e, input logic [26:0] m, input logic sp);
        va[nv] = a; vb[nv] = b; vs[nv] = s;
        ve[nv] = '{sg: sg, e: e, m: m, sp: sp};
        nv++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int i);
        logic acc;
        op_a_i = va[i]; op_b_i = vb[i]; sub_i = vs[i]; in_valid_i = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
        end
        if (acc) q.push_back(ve[i]);
        else chk("accept_timeout", 32'd0, 32'd1);
        in_valid_i = 1'b0;
    endtask

    // Monitor: handshake rule, stall stability, and in-order result checking.
    initial begin
        logic prev_stall;
        exp_t saved, e;
        prev_stall = 1'b0;
        saved = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                chk("in_ready", {31'd0, in_ready_o}, {31'd0, !out_valid_o || out_ready_i});
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
                    chk("hold_data", {sign_o, exponent_o, mantissa_o[22:0]}, {saved.sg, saved.e, saved.m[22:0]});
                    chk("hold_mant_hi", {28'd0, mantissa_o[26:23]}, {28'd0, saved.m[26:23]});
                end
                if (out_valid_o && out_ready_i) begin
                    if (q.size() == 0) begin
                        chk("spurious_result", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("sign", {31'd0, sign_o}, {31'd0, e.sg});
                        chk("exponent", {24'd0, exponent_o}, {24'd0, e.e});
                        chk("mantissa", {5'd0, mantissa_o}, {5'd0, e.m});
                        chk("special", {31'd0, special_o}, {31'd0, e.sp});
                    end
                end
                prev_stall = out_valid_o && !out_ready_i;
                saved = '{sg: sign_o, e: exponent_o, m: mantissa_o, sp: special_o};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        addv(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 8'd128, 27'h4000000, 1'b0);
        addv(32'h3FC00000, 32'h3FC00000, 1'b1, 1'b0, 8'd0,   27'h0000000, 1'b0);
        addv(32'h3F800000, 32'h30800000, 1'b0, 1'b0, 8'd127, 27'h4000001, 1'b0);
        addv(32'h3F800000, 32'h3F000000, 1'b0, 1'b0, 8'd127, 27'h6000000, 1'b0);
        addv(32'h3F000000, 32'h3F800000, 1'b1, 1'b1, 8'd127, 27'h2000000, 1'b0);
        addv(32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 8'd255, 27'h0000000, 1'b1);
        addv(32'h00000000, 32'h80000000, 1'b0, 1'b0, 8'd0,   27'h0000000, 1'b0);
        addv(32'h80000000, 32'h00000000, 1'b1, 1'b1, 8'd0,   27'h0000000, 1'b0);
        addv(32'h40400000, 32'h3F800000, 1'b0, 1'b0, 8'd129, 27'h4000000, 1'b0);
        addv(32'h3F800000, 32'h3B800001, 1'b0, 1'b0, 8'd127, 27'h4040001, 1'b0);
        addv(32'h3F800000, 32'h32800000, 1'b0, 1'b0, 8'd127, 27'h4000001, 1'b0);
        addv(32'h3F800000, 32'h32000000, 1'b0, 1'b0, 8'd127, 27'h4000001, 1'b0);
        addv(32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 8'd255, 27'h0000000, 1'b1);
        addv(32'h3F800000, 32'hFF800000, 1'b0, 1'b1, 8'd255, 27'h0000000, 1'b1);
        addv(32'h3FFFFFFF, 32'h3E000001, 1'b0, 1'b0, 8'd128, 27'h43FFFFD, 1'b0);
        addv(32'h3F800000, 32'h3B800001, 1'b1, 1'b0, 8'd127, 27'h3FBFFFF, 1'b0);
        addv(32'h00400000, 32'h3F800000, 1'b0, 1'b0, 8'd127, 27'h4000000, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_outputs", {sign_o, special_o, exponent_o, mantissa_o[21:0]}, 32'd0);
        chk("rst_mant_hi", {27'd0, mantissa_o[26:22]}, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // Latency: accepted at one edge, valid after the third edge.
        send(0);
        @(negedge clk);
        chk("latency_c1", {31'd0, out_valid_o}, 32'd0);
        @(negedge clk);
        chk("latency_c2", {31'd0, out_valid_o}, 32'd0);
        @(negedge clk);
        chk("latency_c3", {31'd0, out_valid_o}, 32'd1);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;

        // All vectors back to back under a 1,0,0,1 ready pattern.
        fork
            begin
                for (int i = 0; i < nv; i++) send(i);
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    out_ready_i = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                out_ready_i = 1'b1;
            end
        join
        for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_stream", q.size(), 32'd0);

        // Reset with three operations in flight.
        out_ready_i = 1'b0;
        send(0);
        send(8);
        send(3);
        rst_i = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("midrst_outputs", {sign_o, special_o, exponent_o, mantissa_o[21:0]}, 32'd0);
        chk("midrst_mant_hi", {27'd0, mantissa_o[26:22]}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(5);
        for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_after_reset", q.size(), 32'd0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
